// File: rtl/lc3_pkg.sv
// lc3_pkg -- shared definitions for the LC-3 decode stage.
// Contents: opcode values, control-field encodings, E_Control bit offsets,
// the decoded-control bundle type and a helper that packs E_Control.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // alu_control
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_AND = 2'd1;
    localparam logic [1:0] ALU_NOT = 2'd2;

    // pcselect1: source of the address offset
    localparam logic [1:0] PC1_NONE  = 2'd0;
    localparam logic [1:0] PC1_OFF9  = 2'd1;
    localparam logic [1:0] PC1_OFF6  = 2'd2;
    localparam logic [1:0] PC1_BASER = 2'd3;

    // W_Control: writeback source
    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PCOFF = 2'd2;

    // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
    localparam int E_ALU_LSB = 4;
    localparam int E_PC1_LSB = 2;
    localparam int E_PC2_BIT = 1;
    localparam int E_OP2_BIT = 0;

    typedef struct packed {
        logic [5:0] e;
        logic [1:0] w;
        logic       m;
        logic       illegal;
    } dec_ctl_t;

    function automatic logic [5:0] pack_e(input logic [1:0] alu,
                                          input logic [1:0] pc1,
                                          input logic       pc2,
                                          input logic       op2);
        logic [5:0] e;
        e = '0;
        e[E_ALU_LSB +: 2] = alu;
        e[E_PC1_LSB +: 2] = pc1;
        e[E_PC2_BIT]      = pc2;
        e[E_OP2_BIT]      = op2;
        return e;
    endfunction

endpackage

// File: rtl/lc3_decode_lut.sv
// lc3_decode_lut -- purely combinational LC-3 opcode decoder.
// Ports:
//   i_instr : 16-bit instruction word
//   o_ctl   : decoded control bundle (E/W/M controls and illegal flag)
module lc3_decode_lut
    import lc3_pkg::*;
(
    input  logic [15:0] i_instr,
    output dec_ctl_t    o_ctl
);

    logic [3:0] w_op;
    logic       w_op2_imm;
    logic       w_unused_bits;

    assign w_op          = i_instr[15:12];
    // op2select picks the register operand when the immediate flag is clear
    assign w_op2_imm     = ~i_instr[5];
    assign w_unused_bits = ^{i_instr[11:6], i_instr[4:0]};

    always_comb begin
        o_ctl = '0;
        case (w_op)
            OP_BR:  o_ctl.e = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
            OP_JMP: o_ctl.e = pack_e(ALU_ADD, PC1_BASER, 1'b0, 1'b0);
            OP_ADD: begin
                o_ctl.e = pack_e(ALU_ADD, PC1_NONE, 1'b0, w_op2_imm);
                o_ctl.w = WB_ALU;
            end
            OP_AND: begin
                o_ctl.e = pack_e(ALU_AND, PC1_NONE, 1'b0, w_op2_imm);
                o_ctl.w = WB_ALU;
            end
            OP_NOT: begin
                o_ctl.e = pack_e(ALU_NOT, PC1_NONE, 1'b0, w_op2_imm);
                o_ctl.w = WB_ALU;
            end
            OP_LD: begin
                o_ctl.e = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
                o_ctl.w = WB_MEM;
            end
            OP_LDI: begin
                o_ctl.e = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
                o_ctl.w = WB_MEM;
                o_ctl.m = 1'b1;
            end
            OP_LDR: begin
                o_ctl.e = pack_e(ALU_ADD, PC1_OFF6, 1'b0, 1'b0);
                o_ctl.w = WB_MEM;
            end
            OP_LEA: begin
                o_ctl.e = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
                o_ctl.w = WB_PCOFF;
            end
            OP_ST:  o_ctl.e = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
            OP_STI: begin
                o_ctl.e = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
                o_ctl.m = 1'b1;
            end
            OP_STR: o_ctl.e = pack_e(ALU_ADD, PC1_OFF6, 1'b0, 1'b0);
            default: o_ctl.illegal = 1'b1;  // JSR, RTI, reserved, TRAP
        endcase
    end

endmodule

// File: rtl/lc3_decode_hs.sv
// lc3_decode_hs -- LC-3 decode stage with valid/ready on both sides.
// A main output slot plus an optional skid slot keeps in_ready registered
// (no combinational path from out_ready).
// Ports:
//   i_clock, i_reset (sync, active-high), i_flush
//   i_in_valid / o_in_ready / i_dout / i_npc_in      : fetch side
//   o_out_valid / i_out_ready                         : execute side
//   o_ir, o_npc_out, o_e_control, o_w_control, o_mem_control,
//   o_sr1, o_sr2, o_dr, o_illegal                     : decoded bundle
//   o_decode_count                                    : saturating accept count
module lc3_decode_hs
    import lc3_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int IR_W    = 16,
    parameter int CNT_W   = 16,
    parameter int SKID_EN = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [IR_W-1:0]  i_dout,
    input  logic [PC_W-1:0]  i_npc_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [IR_W-1:0]  o_ir,
    output logic [PC_W-1:0]  o_npc_out,
    output logic [5:0]       o_e_control,
    output logic [1:0]       o_w_control,
    output logic             o_mem_control,
    output logic [2:0]       o_sr1,
    output logic [2:0]       o_sr2,
    output logic [2:0]       o_dr,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_decode_count
);

    generate
        if (IR_W != 16) begin : g_ir_w_check
            $error("lc3_decode_hs: IR_W must be 16");
        end
    endgenerate

    dec_ctl_t         w_ctl;

    logic             r_m_valid;
    logic [IR_W-1:0]  r_m_ir;
    logic [PC_W-1:0]  r_m_npc;
    dec_ctl_t         r_m_ctl;

    logic             r_s_valid;
    logic [IR_W-1:0]  r_s_ir;
    logic [PC_W-1:0]  r_s_npc;
    dec_ctl_t         r_s_ctl;

    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_drain;
    logic             w_m_valid_nxt;
    logic             w_s_valid_nxt;
    logic             w_m_load_in;
    logic             w_m_load_skid;
    logic             w_s_load;
    logic             w_cnt_inc;

    lc3_decode_lut u_lut (
        .i_instr (i_dout),
        .o_ctl   (w_ctl)
    );

    assign w_in_ready = (SKID_EN != 0) ? r_in_ready : (i_out_ready | ~r_m_valid);
    assign w_accept   = i_in_valid & w_in_ready;
    assign w_drain    = r_m_valid & i_out_ready;
    assign w_cnt_inc  = w_accept & ~i_flush;

    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_s_valid_nxt = r_s_valid;
        w_m_load_in   = 1'b0;
        w_m_load_skid = 1'b0;
        w_s_load      = 1'b0;
        if (i_flush) begin
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
        end else if (r_s_valid) begin
            // in_ready is low while the skid slot is full, so no accept here
            if (w_drain) begin
                w_m_load_skid = 1'b1;
                w_s_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            if (!r_m_valid || w_drain) begin
                w_m_load_in   = 1'b1;
                w_m_valid_nxt = 1'b1;
            end else if (SKID_EN != 0) begin
                w_s_load      = 1'b1;
                w_s_valid_nxt = 1'b1;
            end
        end else if (w_drain) begin
            w_m_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_m_valid  <= 1'b0;
            r_m_ir     <= '0;
            r_m_npc    <= '0;
            r_m_ctl    <= '0;
            r_s_valid  <= 1'b0;
            r_s_ir     <= '0;
            r_s_npc    <= '0;
            r_s_ctl    <= '0;
            r_in_ready <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_m_valid  <= w_m_valid_nxt;
            r_s_valid  <= w_s_valid_nxt;
            r_in_ready <= ~w_s_valid_nxt;
            if (w_m_load_in) begin
                r_m_ir  <= i_dout;
                r_m_npc <= i_npc_in;
                r_m_ctl <= w_ctl;
            end else if (w_m_load_skid) begin
                r_m_ir  <= r_s_ir;
                r_m_npc <= r_s_npc;
                r_m_ctl <= r_s_ctl;
            end
            if (w_s_load) begin
                r_s_ir  <= i_dout;
                r_s_npc <= i_npc_in;
                r_s_ctl <= w_ctl;
            end
            if (w_cnt_inc && (r_cnt != '1)) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_in_ready     = w_in_ready;
    assign o_out_valid    = r_m_valid;
    assign o_ir           = r_m_ir;
    assign o_npc_out      = r_m_npc;
    assign o_e_control    = r_m_ctl.e;
    assign o_w_control    = r_m_ctl.w;
    assign o_mem_control  = r_m_ctl.m;
    assign o_illegal      = r_m_ctl.illegal;
    assign o_sr1          = r_m_ir[8:6];
    assign o_sr2          = r_m_ir[2:0];
    assign o_dr           = r_m_ir[11:9];
    assign o_decode_count = r_cnt;

endmodule

// File: tb/tb_lc3_decode_hs.sv
// tb_lc3_decode_hs -- directed testbench for lc3_decode_hs.
module tb_lc3_decode_hs;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [15:0] dout, npc_in;
    logic        in_ready, out_valid, mem_control, illegal;
    logic [15:0] ir, npc_out, decode_count;
    logic [5:0]  e_control;
    logic [1:0]  w_control;
    logic [2:0]  sr1, sr2, dr;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    lc3_decode_hs #(.PC_W(16), .IR_W(16), .CNT_W(16), .SKID_EN(1)) dut (
        .i_clock        (clk),
        .i_reset        (reset),
        .i_flush        (flush),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_dout         (dout),
        .i_npc_in       (npc_in),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_ir           (ir),
        .o_npc_out      (npc_out),
        .o_e_control    (e_control),
        .o_w_control    (w_control),
        .o_mem_control  (mem_control),
        .o_sr1          (sr1),
        .o_sr2          (sr2),
        .o_dr           (dr),
        .o_illegal      (illegal),
        .o_decode_count (decode_count)
    );

    task automatic drive(input logic v, input logic [15:0] d, input logic [15:0] n,
                         input logic rdy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        dout      = d;
        npc_in    = n;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; dout = 16'h12A3;
        npc_in = 16'h1234; out_ready = 1'b1;
        step(); step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        tests++; if (decode_count !== 16'h0) begin fails++; $display("FAIL reset_count got %h exp 0", decode_count); end
        tests++; if ({ir, npc_out, e_control, w_control, mem_control, illegal} !== '0) begin
            fails++; $display("FAIL reset_outputs ir %h npc %h e %b w %h m %b ill %b exp all 0",
                              ir, npc_out, e_control, w_control, mem_control, illegal);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        reset = 1'b0;
        step();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_add();
        drive(1'b1, 16'h12A3, 16'h3000, 1'b1, 1'b0);
        step(); exp_cnt++;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %b exp 1", out_valid); end
        tests++; if ({e_control, w_control, mem_control, illegal} !== 10'b0) begin
            fails++; $display("FAIL add_ctl e %b w %h m %b ill %b exp all 0", e_control, w_control, mem_control, illegal);
        end
        tests++; if ({dr, sr1, sr2} !== {3'd1, 3'd2, 3'd3}) begin
            fails++; $display("FAIL add_regs dr %0d sr1 %0d sr2 %0d exp 1 2 3", dr, sr1, sr2);
        end
        tests++; if (decode_count !== exp_cnt[15:0]) begin fails++; $display("FAIL add_count got %h exp %h", decode_count, exp_cnt[15:0]); end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_ldi();
        drive(1'b1, 16'hA005, 16'h3001, 1'b1, 1'b0);
        step(); exp_cnt++;
        tests++; if (e_control !== 6'b000110) begin fails++; $display("FAIL ldi_e got %b exp 000110", e_control); end
        tests++; if (w_control !== 2'd1 || mem_control !== 1'b1) begin
            fails++; $display("FAIL ldi_wm w %h m %b exp 1 1", w_control, mem_control);
        end
        tests++; if (npc_out !== 16'h3001 || ir !== 16'hA005) begin
            fails++; $display("FAIL ldi_data npc %h ir %h exp 3001 a005", npc_out, ir);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'h12A3, 16'h4001, 1'b0, 1'b0);
        step(); exp_cnt++;
        tests++; if (in_ready !== 1'b1 || ir !== 16'h12A3) begin
            fails++; $display("FAIL b2b_first in_ready %b ir %h exp 1 12a3", in_ready, ir);
        end
        drive(1'b1, 16'h5042, 16'h4002, 1'b0, 1'b0);
        step(); exp_cnt++;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready got %b exp 0", in_ready); end
        drive(1'b1, 16'h927F, 16'h4003, 1'b0, 1'b0);
        step();
        tests++; if (ir !== 16'h12A3 || npc_out !== 16'h4001 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++; $display("FAIL b2b_hold ir %h npc %h v %b rdy %b exp 12a3 4001 1 0", ir, npc_out, out_valid, in_ready);
        end
        drive(1'b1, 16'h927F, 16'h4003, 1'b1, 1'b0);
        step();
        tests++; if (ir !== 16'h5042 || e_control !== 6'b010001 || npc_out !== 16'h4002) begin
            fails++; $display("FAIL b2b_and ir %h e %b npc %h exp 5042 010001 4002", ir, e_control, npc_out);
        end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_back got %b exp 1", in_ready); end
        drive(1'b1, 16'h927F, 16'h4003, 1'b1, 1'b0);
        step(); exp_cnt++;
        tests++; if (ir !== 16'h927F || e_control !== 6'b100000 || w_control !== 2'd0) begin
            fails++; $display("FAIL b2b_not ir %h e %b w %h exp 927f 100000 0", ir, e_control, w_control);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        tests++; if (out_valid !== 1'b0 || decode_count !== exp_cnt[15:0]) begin
            fails++; $display("FAIL b2b_end v %b cnt %h exp 0 %h", out_valid, decode_count, exp_cnt[15:0]);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h3200, 16'h5001, 1'b0, 1'b0);
        step(); exp_cnt++;
        tests++; if (e_control !== 6'b000110 || w_control !== 2'd0 || mem_control !== 1'b0) begin
            fails++; $display("FAIL st_ctl e %b w %h m %b exp 000110 0 0", e_control, w_control, mem_control);
        end
        drive(1'b1, 16'h6283, 16'h5002, 1'b0, 1'b0);
        step(); exp_cnt++;
        drive(1'b1, 16'h1000, 16'h5003, 1'b0, 1'b1);
        step();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_full v %b rdy %b exp 0 1", out_valid, in_ready);
        end
        tests++; if (decode_count !== exp_cnt[15:0]) begin fails++; $display("FAIL flush_full_cnt got %h exp %h", decode_count, exp_cnt[15:0]); end
        drive(1'b1, 16'h3200, 16'h5004, 1'b0, 1'b0);
        step(); exp_cnt++;
        drive(1'b1, 16'h6283, 16'h5005, 1'b1, 1'b1);
        step();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || decode_count !== exp_cnt[15:0]) begin
            fails++; $display("FAIL flush_drop v %b rdy %b cnt %h exp 0 1 %h", out_valid, in_ready, decode_count, exp_cnt[15:0]);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_ghost got %b exp 0", out_valid); end
    endtask

    task automatic test_illegal();
        drive(1'b1, 16'hF025, 16'h6001, 1'b1, 1'b0);
        step(); exp_cnt++;
        tests++; if (illegal !== 1'b1 || out_valid !== 1'b1 || {e_control, w_control, mem_control} !== 9'b0) begin
            fails++; $display("FAIL trap ill %b v %b e %b w %h m %b exp 1 1 0 0 0", illegal, out_valid, e_control, w_control, mem_control);
        end
        drive(1'b1, 16'hE00A, 16'h6002, 1'b1, 1'b0);
        step(); exp_cnt++;
        tests++; if (w_control !== 2'd2 || e_control !== 6'b000110 || illegal !== 1'b0) begin
            fails++; $display("FAIL lea w %h e %b ill %b exp 2 000110 0", w_control, e_control, illegal);
        end
        drive(1'b1, 16'hC1C0, 16'h6003, 1'b1, 1'b0);
        step(); exp_cnt++;
        tests++; if (e_control !== 6'b001100 || sr1 !== 3'd7) begin
            fails++; $display("FAIL jmp e %b sr1 %0d exp 001100 7", e_control, sr1);
        end
        drive(1'b1, 16'h6283, 16'h6004, 1'b1, 1'b0);
        step(); exp_cnt++;
        tests++; if (e_control !== 6'b001000 || w_control !== 2'd1) begin
            fails++; $display("FAIL ldr e %b w %h exp 001000 1", e_control, w_control);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 16'h12A3, 16'h7001, 1'b0, 1'b0);
        step(); exp_cnt++;
        drive(1'b1, 16'h5042, 16'h7002, 1'b0, 1'b0);
        step(); exp_cnt++;
        tests++; if (decode_count !== exp_cnt[15:0]) begin fails++; $display("FAIL pre_reset_cnt got %h exp %h", decode_count, exp_cnt[15:0]); end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        reset = 1'b1;
        step(); exp_cnt = 0;
        tests++; if ({out_valid, in_ready, ir, npc_out, e_control, w_control, mem_control, illegal, decode_count} !== '0) begin
            fails++; $display("FAIL mid_reset v %b rdy %b ir %h npc %h e %b cnt %h exp all 0",
                              out_valid, in_ready, ir, npc_out, e_control, decode_count);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        reset = 1'b0;
        step();
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL after_mid_reset rdy %b v %b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_saturate();
        drive(1'b1, 16'h1042, 16'h8000, 1'b1, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        tests++; if (decode_count !== 16'hFFFE) begin fails++; $display("FAIL sat_near got %h exp fffe", decode_count); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (decode_count !== 16'hFFFF) begin fails++; $display("FAIL sat_hold got %h exp ffff", decode_count); end
        tests++; if (out_valid !== 1'b1 || ir !== 16'h1042 || e_control !== 6'b000001) begin
            fails++; $display("FAIL sat_stream v %b ir %h e %b exp 1 1042 000001", out_valid, ir, e_control);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldi();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_reset_mid_stall();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lc3_decode_hs.md
Name: lc3_decode_hs

Overview:
- Next-generation LC-3 decode stage. It sits between fetch and execute.
- Adds a valid/ready handshake on both sides, a 2-entry skid buffer, a flush input, illegal-opcode flagging, register-field extraction and a saturating decoded-instruction counter.
- Width is parametrised so the same block serves the 16-bit core and wider-address variants.
- Control encodings are the corrected, released ones.

Parameters:
- PC_W, 16, width of npc_in/npc_out.
- IR_W, 16, instruction width; must be 16 in this generation and is checked at elaboration.
- CNT_W, 16, width of the decoded-instruction counter.
- SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single output register, with in_ready = out_ready | ~out_valid.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- flush, in, 1, discard all buffered instructions.
- in_valid, in, 1, fetch presents an instruction.
- in_ready, out, 1, decode can accept.
- dout, in, IR_W, instruction from fetch.
- npc_in, in, PC_W, next-PC of the instruction.
- out_valid, out, 1, decoded bundle valid.
- out_ready, in, 1, execute accepts the bundle.
- IR, out, IR_W, registered instruction.
- npc_out, out, PC_W, registered npc_in (no increment).
- E_Control, out, 6, {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- W_Control, out, 2, writeback select.
- Mem_Control, out, 1, indirect memory access (LDI/STI).
- sr1, out, 3, IR[8:6].
- sr2, out, 3, IR[2:0].
- dr, out, 3, IR[11:9].
- illegal, out, 1, unsupported opcode.
- decode_count, out, CNT_W, saturating count of accepted instructions.

Behaviour:
- Reset: all outputs 0; both buffer slots invalid; in_ready = 1 in the cycle after reset deasserts.
- Accept rule: a transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Latency: 1 cycle from accept to out_valid when the buffer is empty.
- Output registers: decode is combinational on dout. All control fields are registered into the main slot.
- Skid slot: used only when the main slot is valid and out_ready = 0 in the accept cycle.
- in_ready = ~skid_valid, registered, so it has no combinational path from out_ready.
- When the main slot drains, the skid slot moves to main in the same edge.
- Simultaneous accept and drain with the skid slot empty: the new instruction goes to main.
- Ordering: strict FIFO; no instruction is lost or duplicated under any valid/ready pattern.
- Output stability: while out_valid & ~out_ready, all outputs hold stable.
- flush:
  - Next cycle, both slots are invalid and out_valid = 0.
  - An instruction offered in the flush cycle is dropped and not counted.
  - flush overrides a simultaneous accept and drain.
  - IR, npc_out and the control outputs may keep stale values; consumers qualify them with out_valid.
- Decode table (by opcode = IR[15:12]; unlisted fields are 0):
  - BR 0000: pcselect1 = 1, pcselect2 = 1.
  - JMP 1100: pcselect1 = 3, pcselect2 = 0.
  - ADD 0001 / AND 0101 / NOT 1001: alu_control = 0 / 1 / 2; op2select = ~IR[5]; W_Control = 0.
  - LD 0010 / LDI 1010: pcselect1 = 1, pcselect2 = 1, W_Control = 1; LDI also sets Mem_Control = 1.
  - LDR 0110: pcselect1 = 2, pcselect2 = 0, W_Control = 1.
  - LEA 1110: pcselect1 = 1, pcselect2 = 1, W_Control = 2.
  - ST 0011 / STI 1011: pcselect1 = 1, pcselect2 = 1; STI also sets Mem_Control = 1.
  - STR 0111: pcselect1 = 2, pcselect2 = 0.
  - 0100, 1000, 1101, 1111: illegal = 1, all controls 0; the instruction still flows through the pipeline.
- decode_count: increments on each accept; saturates at all-ones; cleared only by reset; unaffected by flush.
- Reset mid-operation: the buffer is emptied; in-flight instructions are discarded.

Decomposition:
- Shared package lc3_pkg holds:
  - opcode localparams (OP_BR … OP_TRAP);
  - the alu_control, pcselect1 and W_Control encodings;
  - the E_Control field offsets;
  - a packed struct dec_ctl_t {E, W, M, illegal}.
- Sub-module lc3_decode_lut: purely combinational, dout → dec_ctl_t. It is instanced once and reused by later superscalar decode.

Test Plan:
- ADD R1,R2,#3 (0x12A3), out_ready = 1 → next cycle: out_valid = 1, E_Control = 6'b000000, W_Control = 0, Mem_Control = 0, dr = 1, sr1 = 2.
- LDI R0 (0xA005), npc_in = 0x3001 → E_Control = 6'b000110, W_Control = 1, Mem_Control = 1, npc_out = 0x3001.
- Back-to-back 0x12A3, 0x5042, 0x927F with out_ready = 0 for 3 cycles:
  - in_ready drops after the 2nd instruction is accepted; the 3rd is held.
  - After out_ready = 1, outputs appear in order; AND gives alu_control = 1, op2select = 1; NOT gives alu_control = 2.
- Buffer full (2 entries) plus flush and in_valid together → next cycle: out_valid = 0, in_ready = 1; decode_count unchanged by the dropped instruction.
- TRAP 0xF025 → illegal = 1, E_Control = 0, W_Control = 0, Mem_Control = 0. LEA 0xE00A → W_Control = 2, E_Control = 6'b000110.
- Preload decode_count near all-ones, then accept 3 instructions → count holds at 0xFFFF. Reset asserted mid-stall → next cycle all outputs 0, out_valid = 0.
